uart_transmitter_fifo: RTL and testbench
========================================

// Module: uart_transmitter_fifo
// PURPOSE
//   Parametrised UART transmit engine with a small input FIFO and configurable frame
//   format (data bits, parity, stop bits, oversample ratio). It serialises bytes onto
//   RsTx, LSB first. The FIFO lets the upstream producer queue words while a frame is
//   on the line. Consecutive frames go out back-to-back with no idle gap.
// PARAMETERS
//   DATA_BITS   8   data bits per frame; legal 5..9
//   OVERSAMPLE  16  uart_samplig_clk cycles per bit; legal >=2
//   PARITY_MODE 0   0=none, 1=even, 2=odd; 3 is illegal
//   STOP_BITS   1   stop bits per frame; legal 1..2
//   FIFO_DEPTH  4   FIFO entries; power of 2, >=2
// PORTS
//   uart_samplig_clk  in   1                       bit-sampling clock; all state on rising edge
//   reset_n           in   1                       asynchronous, active-low reset
//   valid             in   1                       data_to_xmit holds a word to queue
//   ready             out  1                       FIFO not full; ready = (count != FIFO_DEPTH)
//   data_to_xmit      in   DATA_BITS               word to transmit
//   RsTx              out  1                       serial line, idle high
//   busy              out  1                       frame in progress or FIFO non-empty
//   fifo_count        out  $clog2(FIFO_DEPTH)+1    number of queued words
// BEHAVIOUR
//   Reset (async assert, sync release): RsTx=1, busy=0, fifo_count=0, ready=1, FSM=IDLE.
//     Pointers and counters clear. Any frame in progress is aborted and the line goes
//     high immediately.
//   Push: a word is written on an edge with valid&&ready. While full, ready=0 and valid
//     is ignored, even if a pop happens in the same cycle.
//   Push+pop in the same cycle (not full): count is unchanged and both operations happen.
//   Pointers wrap modulo FIFO_DEPTH.
//   FSM states: IDLE, START, DATA, PARITY, STOP.
//     IDLE: RsTx=1. If the FIFO is non-empty, pop into the shift register and enter START.
//       The pop edge drives RsTx=0.
//     Latency: a word pushed at edge N into an empty, idle block drives RsTx low at
//       edge N+1.
//     Every bit lasts exactly OVERSAMPLE cycles, timed by bit_cnt (0..OVERSAMPLE-1).
//       Transitions happen on the edge where bit_cnt==OVERSAMPLE-1.
//     START -> DATA. DATA shifts out DATA_BITS bits, LSB first.
//     DATA -> PARITY if PARITY_MODE!=0, else DATA -> STOP.
//     PARITY bit: even mode = XOR of the data bits; odd mode = inverted XOR.
//     STOP holds RsTx=1 for STOP_BITS*OVERSAMPLE cycles.
//     At the end of STOP: if the FIFO is non-empty, pop and drive the next START bit on
//       that same edge (zero idle cycles); otherwise go to IDLE.
//   Frame length: (1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS) * OVERSAMPLE cycles.
//   RsTx is registered and glitch-free. It changes only at bit boundaries.
//   busy=1 from the edge after the first push until the last stop bit completes with
//     the FIFO empty.
//   valid may toggle freely. A queued word is never dropped, duplicated or reordered.
//   Illegal parameters stop elaboration with $error.
// TESTING
//   1. Defaults (8N1, OS=16). Push 0xA5 -> RsTx low at +1 edge; bits 1,0,1,0,0,1,0,1
//      at 16 cycles each; stop high; frame = 160 cycles; busy drops after the stop bit.
//   2. PARITY_MODE=1, push 0xA5 -> parity bit 0, frame = 176 cycles. PARITY_MODE=2 ->
//      parity bit 1.
//   3. FIFO_DEPTH=4, valid held high with 0x01..0x06 -> 5 words accepted (1 popped plus
//      4 queued); ready=0 while count=4; 5 frames back-to-back with no idle cycle between
//      a stop bit and the next start bit.
//   4. Push on the same edge that ends a stop bit with count=1 -> count stays 1; the next
//      frame starts immediately; data order is preserved.
//   5. Assert reset_n=0 at cycle 70 of a frame with 2 words queued -> RsTx=1 with no clock
//      edge; after release: count=0, ready=1, busy=0, no residual frame.
//   6. DATA_BITS=7, STOP_BITS=2, OS=4, push 0x55 -> 7 data bits 1,0,1,0,1,0,1; stop high
//      for 8 cycles; frame = 40 cycles.

Source files
------------

// File: rtl/uart_transmitter_fifo.sv
// UART transmit engine: a small word FIFO feeds a serialiser that sends
// start, data (LSB first), optional parity and stop bits, back-to-back.
module uart_transmitter_fifo #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          uart_samplig_clk,
  input  logic                          reset_n,
  input  logic                          valid,
  output logic                          ready,
  input  logic [DATA_BITS-1:0]          data_to_xmit,
  output logic                          RsTx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BCW   = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("DATA_BITS must be 5..9");
    end
    if (OVERSAMPLE < 2) begin : g_bad_oversample
      $error("OVERSAMPLE must be >= 2");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
      $error("PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_reg, state_next;
  logic [BCW-1:0]       bit_cnt_reg, bit_cnt_next;
  logic [IDX_W-1:0]     bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 parity_reg, parity_next;
  logic                 tx_reg, tx_next;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg;
  logic [DATA_BITS-1:0] rd_data;
  logic                 push, pop, load, fifo_empty, bit_end;

  assign ready      = (count_reg != CNT_W'(FIFO_DEPTH));
  assign push       = valid && ready;
  assign fifo_empty = (count_reg == '0);
  assign rd_data    = mem[rd_ptr_reg];
  assign bit_end    = (bit_cnt_reg == BCW'(OVERSAMPLE - 1));
  assign fifo_count = count_reg;
  assign RsTx       = tx_reg;
  assign busy       = (state_reg != IDLE) || !fifo_empty;

  always_ff @(posedge uart_samplig_clk) begin
    if (push) mem[wr_ptr_reg] <= data_to_xmit;
  end

  always_ff @(posedge uart_samplig_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      tx_reg      <= 1'b1;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg   <= count_reg + CNT_W'(push) - CNT_W'(pop);
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      tx_reg      <= tx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_end ? '0 : bit_cnt_reg + 1'b1;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    tx_next      = tx_reg;
    load         = 1'b0;
    pop          = 1'b0;

    case (state_reg)
      IDLE: begin
        tx_next      = 1'b1;
        bit_cnt_next = '0;
        if (!fifo_empty) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          tx_next      = shift_reg[0];
          shift_next   = shift_reg >> 1;
          bit_idx_next = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_reg == IDX_W'(DATA_BITS - 1)) begin
            bit_idx_next = '0;
            if (PARITY_MODE != 0) begin
              state_next = PARITY;
              tx_next    = parity_reg;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            bit_idx_next = bit_idx_reg + 1'b1;
            tx_next      = shift_reg[0];
            shift_next   = shift_reg >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next   = STOP;
          tx_next      = 1'b1;
          bit_idx_next = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_idx_reg == IDX_W'(STOP_BITS - 1)) begin
            // Chain straight into the next start bit when more words are waiting.
            if (!fifo_empty) load = 1'b1;
            else             state_next = IDLE;
          end else begin
            bit_idx_next = bit_idx_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase

    if (load) begin
      pop          = 1'b1;
      state_next   = START;
      shift_next   = rd_data;
      parity_next  = (^rd_data) ^ (PARITY_MODE == 2);
      tx_next      = 1'b0;
      bit_cnt_next = '0;
      bit_idx_next = '0;
    end
  end

endmodule

// File: tb/tb_uart_transmitter_fifo.sv
// Bench for uart_transmitter_fifo: four parameter variants, a word scoreboard
// and a line receiver that checks every cycle of every bit.
module tb_uart_transmitter_fifo;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] valid_v = '0;
  logic [7:0] din_v [4];
  logic [3:0] ready_v, tx_v, busy_v;
  logic [2:0] cnt_v [4];
  int         cyc = 0;
  int         n_total = 0;
  int         n_pass = 0;
  logic [8:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // d0: 8N1 OS16, d1: 8E1 OS16, d2: 8O1 OS4, d3: 7N2 OS4
  uart_transmitter_fifo u_d0 (
    .uart_samplig_clk(clk), .reset_n(reset_n), .valid(valid_v[0]), .ready(ready_v[0]),
    .data_to_xmit(din_v[0]), .RsTx(tx_v[0]), .busy(busy_v[0]), .fifo_count(cnt_v[0]));
  uart_transmitter_fifo #(.PARITY_MODE(1)) u_d1 (
    .uart_samplig_clk(clk), .reset_n(reset_n), .valid(valid_v[1]), .ready(ready_v[1]),
    .data_to_xmit(din_v[1]), .RsTx(tx_v[1]), .busy(busy_v[1]), .fifo_count(cnt_v[1]));
  uart_transmitter_fifo #(.PARITY_MODE(2), .OVERSAMPLE(4)) u_d2 (
    .uart_samplig_clk(clk), .reset_n(reset_n), .valid(valid_v[2]), .ready(ready_v[2]),
    .data_to_xmit(din_v[2]), .RsTx(tx_v[2]), .busy(busy_v[2]), .fifo_count(cnt_v[2]));
  uart_transmitter_fifo #(.DATA_BITS(7), .STOP_BITS(2), .OVERSAMPLE(4)) u_d3 (
    .uart_samplig_clk(clk), .reset_n(reset_n), .valid(valid_v[3]), .ready(ready_v[3]),
    .data_to_xmit(din_v[3][6:0]), .RsTx(tx_v[3]), .busy(busy_v[3]), .fifo_count(cnt_v[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Caller must be at a negedge; returns at the negedge after the push edge.
  task automatic push(input int idx, input logic [7:0] d, output int edge_n, output bit acc);
    valid_v[idx] = 1'b1;
    din_v[idx]   = d;
    acc          = ready_v[idx];
    edge_n       = cyc + 1;
    if (acc) exp_q.push_back({1'b0, d});
    @(negedge clk);
    valid_v[idx] = 1'b0;
    $display("push d%0d word 0x%0h edge %0d accepted %0d", idx, d, edge_n, acc);
  endtask

  // Waits for a start bit, then checks every cycle of every bit against the
  // scoreboard word. Returns at the negedge of the final stop-bit cycle.
  task automatic rx_frame(input int idx, input int os, input int dbits, input int pmode,
                          input int sbits, output int start_c);
    logic [8:0] w;
    logic       e, par, bad;
    int         waited, nseg;
    start_c = -1;
    waited  = 0;
    @(negedge clk);
    while (tx_v[idx] !== 1'b0 && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    if (tx_v[idx] !== 1'b0) begin
      check($sformatf("d%0d_start_timeout", idx), 32'd0, 32'd1);
      return;
    end
    start_c = cyc;
    if (exp_q.size() == 0) begin
      check($sformatf("d%0d_unexpected_frame", idx), 32'd0, 32'd1);
      w = '0;
    end else begin
      w = exp_q.pop_front();
    end
    par = 1'b0;
    for (int i = 0; i < dbits; i++) par = par ^ w[i];
    if (pmode == 2) par = ~par;
    nseg = 1 + dbits + ((pmode != 0) ? 1 : 0) + sbits;
    for (int s = 0; s < nseg; s++) begin
      if (s == 0)                            e = 1'b0;
      else if (s <= dbits)                   e = w[s-1];
      else if (pmode != 0 && s == dbits + 1) e = par;
      else                                   e = 1'b1;
      bad = 1'b0;
      for (int c = 0; c < os; c++) begin
        if (s != 0 || c != 0) @(negedge clk);
        if (tx_v[idx] !== e) bad = 1'b1;
      end
      check($sformatf("d%0d_w%0h_seg%0d", idx, w, s), {31'd0, bad ? ~e : e}, {31'd0, e});
    end
    $display("frame d%0d word 0x%0h start %0d", idx, w, start_c);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         p, k, k2, s0, c;
    int         st [6];
    bit         acc;
    logic       bad;
    logic [7:0] d;
    for (int i = 0; i < 4; i++) din_v[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", tx_v[0], 1);
    check("rst_busy", busy_v[0], 0);
    check("rst_cnt", cnt_v[0], 0);
    check("rst_ready", ready_v[0], 1);
    reset_n = 1'b1;
    @(negedge clk);

    // 8N1 single word: latency, bit pattern, frame length, busy release
    fork
      push(0, 8'hA5, p, acc);
      rx_frame(0, 16, 8, 0, 1, s0);
    join
    check("t1_latency", s0, p + 1);
    check("t1_len", cyc - s0 + 1, 160);
    check("t1_busy_last_stop", busy_v[0], 1);
    @(negedge clk);
    check("t1_busy_after", busy_v[0], 0);
    check("t1_tx_idle", tx_v[0], 1);

    // valid held high: FIFO fills, 0x06 is held off, frames back-to-back
    fork
      begin
        k = 0;
        for (int i = 0; i < 30; i++) begin
          valid_v[0] = 1'b1;
          din_v[0]   = 8'(k + 1);
          if (ready_v[0]) begin
            exp_q.push_back(9'(k + 1));
            $display("push d0 word 0x%0h edge %0d accepted 1", k + 1, cyc + 1);
            k++;
          end
          @(negedge clk);
        end
        valid_v[0] = 1'b0;
        check("t3_accepted", k, 5);
        check("t3_ready_full", ready_v[0], 0);
        check("t3_cnt_full", cnt_v[0], 4);
      end
      for (int f = 0; f < 5; f++) rx_frame(0, 16, 8, 0, 1, st[f]);
    join
    for (int f = 1; f < 5; f++) check($sformatf("t3_b2b%0d", f), st[f] - st[f-1], 160);
    @(negedge clk);

    // Push on the edge that ends a stop bit while one word is queued
    fork
      begin
        push(0, 8'h3C, p, acc);
        push(0, 8'hC3, k2, acc);
        while (cyc < p + 160) @(negedge clk);
        push(0, 8'h5A, k2, acc);
        check("t4_cnt_same_edge", cnt_v[0], 1);
      end
      for (int f = 0; f < 3; f++) rx_frame(0, 16, 8, 0, 1, st[f]);
    join
    check("t4_latency", st[0], p + 1);
    check("t4_b2b1", st[1] - st[0], 160);
    check("t4_b2b2", st[2] - st[1], 160);
    @(negedge clk);

    // Asynchronous reset mid-frame with two words queued
    push(0, 8'h00, p, acc);
    push(0, 8'hFF, k2, acc);
    push(0, 8'h81, k2, acc);
    while (cyc < p + 1 + 70) @(negedge clk);
    check("t5_cnt_pre", cnt_v[0], 2);
    check("t5_tx_pre", tx_v[0], 0);
    #2 reset_n = 1'b0;
    #1;
    check("t5_tx_async", tx_v[0], 1);
    check("t5_cnt_async", cnt_v[0], 0);
    check("t5_busy_async", busy_v[0], 0);
    check("t5_ready_async", ready_v[0], 1);
    exp_q.delete();
    $display("reset asserted mid-frame at cycle %0d", cyc);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad = 1'b1;
    end
    check("t5_no_residual", bad, 0);
    check("t5_cnt_post", cnt_v[0], 0);
    check("t5_ready_post", ready_v[0], 1);

    // Parity and alternate frame formats
    fork
      push(1, 8'hA5, p, acc);
      rx_frame(1, 16, 8, 1, 1, s0);
    join
    check("t2_even_latency", s0, p + 1);
    check("t2_even_len", cyc - s0 + 1, 176);
    @(negedge clk);
    fork
      push(2, 8'hA5, p, acc);
      rx_frame(2, 4, 8, 2, 1, s0);
    join
    check("t2_odd_len", cyc - s0 + 1, 44);
    @(negedge clk);
    fork
      push(3, 8'h55, p, acc);
      rx_frame(3, 4, 7, 0, 2, s0);
    join
    check("t6_len", cyc - s0 + 1, 40);
    @(negedge clk);
    check("t6_busy_after", busy_v[3], 0);

    // Random words with valid toggling freely
    fork
      begin
        k = 0;
        c = 0;
        while (k < 6 && c < 3000) begin
          valid_v[0] = 1'($urandom_range(0, 1));
          d          = 8'($urandom);
          din_v[0]   = d;
          if (valid_v[0] && ready_v[0]) begin
            exp_q.push_back({1'b0, d});
            $display("push d0 word 0x%0h edge %0d accepted 1", d, cyc + 1);
            k++;
          end
          @(negedge clk);
          c++;
        end
        valid_v[0] = 1'b0;
        check("rnd_pushed", k, 6);
      end
      for (int f = 0; f < 6; f++) rx_frame(0, 16, 8, 0, 1, st[f]);
    join
    check("rnd_sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
